pressure_scan_controller: RTL and testbench
===========================================

Name: pressure_scan_controller

Overview:
- Time-multiplexes one shared pressure analyzer (the existing Pressure_Analyzer block, 6-bit data in, 1-bit warning out) across NUM_CH pressure sensor channels.
- Periodically scans every channel and requires CONFIRM consecutive warnings before raising a latched per-channel alarm. The alarm holds until acknowledged.
- Sits between the sensor input registers and the alarm/display logic.
- The analyzer is instantiated outside this block: combinational path anData -> anWarning, settling within one cycle.

Parameters:
- NUM_CH, 4, number of sensor channels (2..16).
- SCAN_DIV, 8, idle cycles between scans (>=1).
- CONFIRM, 3, consecutive warned scans required to set an alarm (1..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  scanning enable.
- chData  in  6*NUM_CH  flattened sensor samples; channel i = chData[6*i+5:6*i].
- anData  out  6  sample driven to the shared analyzer.
- anWarning  in  1  analyzer warning for anData.
- ackAlarm  in  NUM_CH  per-channel alarm clear, pulse.
- alarm  out  NUM_CH  latched per-channel alarm.
- alarmAny  out  1  OR of alarm.
- curCh  out  clog2(NUM_CH)  channel currently selected.
- scanDone  out  1  one-cycle pulse at the end of each scan.

Behaviour:
- Interface (decided): one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values: all outputs 0, state IDLE, timer 0, all confirm counters 0.
- States:
  - IDLE: when enable=1, the timer counts 0..SCAN_DIV-1. At SCAN_DIV-1 the timer clears, curCh is set to 0 and the FSM goes to SEL. When enable=0, the timer holds at 0.
  - SEL: anData <= slice(curCh), registered. Next state is EVAL.
  - EVAL: sample anWarning and update the filter for curCh.
    - If curCh = NUM_CH-1: assert scanDone, go to IDLE.
    - Otherwise: curCh += 1, go to SEL.
- Scan period with enable held high: SCAN_DIV + 2*NUM_CH cycles (16 at defaults).
- anData holds its last value outside SEL.
- Per-channel filter, updated only in EVAL for the selected channel:
  - anWarning=1: cnt <= min(cnt+1, CONFIRM). When cnt+1 = CONFIRM, alarm[ch] <= 1 in the same edge.
  - anWarning=0: cnt <= 0. The alarm is unaffected.
- Counter width: smallest width that holds CONFIRM. It saturates and never wraps.
- ackAlarm[i] clears alarm[i] on the next edge. cnt[i] is not cleared, so a persisting warning re-raises the alarm on the next EVAL of channel i.
- Simultaneous set and ack on the same channel: set wins.
- alarmAny is the registered OR of the next-state alarm vector, so it is coincident with alarm.
- enable dropped mid-scan: the current scan completes, including scanDone, then the FSM stays in IDLE.
- chData is sampled only in SEL. Changes at other times are ignored.
- Async reset mid-scan: everything returns to reset values immediately. Alarms are lost.

Optional Feature:
- Macro: PRESSURE_SNAPSHOT_EN.
- Defined: adds output `snapData [6*NUM_CH-1:0]`. On the edge that sets alarm[i], snapData slice i captures anData. The slice holds until the next alarm set on that channel. Reset value is 0.
- Undefined: no port and no registers. All other behaviour is identical.

Decomposition:
- Shared include pressure_defs.vh:
  - PDATA_W = 6.
  - FSM state encodings (IDLE=2'd0, SEL=2'd1, EVAL=2'd2).
  - Constant function for clog2.
- Sub-module pressure_ch_filter: confirm counter, alarm latch, ack and optional snapshot. Generated NUM_CH times with inputs update, warn, ack.

Test Plan (defaults, analyzer instantiated in the bench):
1. Reset release with enable=1 and all channels 6'd0 (no warning) -> first scanDone pulse 16 cycles after the first timer count; alarm stays 4'b0000.
2. ch2 = 6'd2 (warns) constant -> alarm[2] rises at the EVAL of ch2 in the 3rd scan; alarmAny=1; other bits stay 0.
3. ch1 alternates 6'd2 and 6'd29 (6'd29 does not warn) every scan -> alarm[1] never sets; internal cnt never exceeds 1.
4. With alarm[2] set and ch2 still 6'd2, pulse ackAlarm[2] -> alarm[2]=0 next cycle, re-set at the next ch2 EVAL. Also drive ack in the same cycle as a set -> alarm stays 1.
5. Drop enable during the SEL of ch1 -> ch1..ch3 are still evaluated and scanDone pulses. The FSM then stays in IDLE with the timer at 0 until enable returns.
6. Assert rst_n=0 during EVAL with alarm[2]=1 -> outputs 0 asynchronously. After release, CONFIRM full scans are needed before alarm[2] is set again.
   - With PRESSURE_SNAPSHOT_EN defined, in scenario 2: snapData[17:12] = 6'd2 after the set.

Source files
------------

// File: rtl/pressure_scan_controller_pkg.sv
// Shared definitions for the pressure scan controller: sample width, FSM states, clog2 helper.
package pressure_scan_controller_pkg;

  localparam int unsigned PDATA_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEL  = 2'd1,
    ST_EVAL = 2'd2
  } scan_state_e;

  // Smallest width able to index v distinct values (0 for v <= 1).
  function automatic int unsigned clog2_f(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/pressure_scan_controller_ch_filter.sv
// Per-channel confirm filter: saturating warning counter, latched alarm with ack.
// PRESSURE_SNAPSHOT_EN adds a snapshot of the analyzer sample on each alarm set.
module pressure_ch_filter
  import pressure_scan_controller_pkg::*;
#(
  parameter int unsigned CONFIRM = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               update_i,
  input  logic               warn_i,
  input  logic               ack_i,
`ifdef PRESSURE_SNAPSHOT_EN
  input  logic [PDATA_W-1:0] data_i,
  output logic [PDATA_W-1:0] snap_o,
`endif
  output logic               alarm_o,
  output logic               alarm_d_c
);

  localparam int unsigned        CNT_W     = clog2_f(CONFIRM + 1);
  localparam logic [CNT_W-1:0]   CONFIRM_V = CNT_W'(CONFIRM);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             alarm_q, alarm_d;
  logic             set_c;

  // Saturating count; a saturated counter keeps re-raising the alarm after an ack.
  always_comb begin
    cnt_d   = cnt_q;
    set_c   = 1'b0;
    alarm_d = alarm_q;
    if (update_i) begin
      if (warn_i) begin
        if (cnt_q != CONFIRM_V) cnt_d = cnt_q + CNT_W'(1);
        set_c = (cnt_d == CONFIRM_V);
      end else begin
        cnt_d = '0;
      end
    end
    if (ack_i) alarm_d = 1'b0;
    if (set_c) alarm_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      alarm_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      alarm_q <= alarm_d;
    end
  end

`ifdef PRESSURE_SNAPSHOT_EN
  logic [PDATA_W-1:0] snap_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_q <= '0;
    end else if (set_c) begin
      snap_q <= data_i;
    end
  end

  assign snap_o = snap_q;
`endif

  assign alarm_o   = alarm_q;
  assign alarm_d_c = alarm_d;

endmodule

// File: rtl/pressure_scan_controller.sv
// Time-multiplexes one shared pressure analyzer across NUM_CH channels with confirmed, latched alarms.
// Define PRESSURE_SNAPSHOT_EN to add the snapData output.
module pressure_scan_controller
  import pressure_scan_controller_pkg::*;
#(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned SCAN_DIV = 8,
  parameter int unsigned CONFIRM  = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic [PDATA_W*NUM_CH-1:0]   chData,
  output logic [PDATA_W-1:0]          anData,
  input  logic                        anWarning,
  input  logic [NUM_CH-1:0]           ackAlarm,
  output logic [NUM_CH-1:0]           alarm,
  output logic                        alarmAny,
  output logic [clog2_f(NUM_CH)-1:0]  curCh,
`ifdef PRESSURE_SNAPSHOT_EN
  output logic [PDATA_W*NUM_CH-1:0]   snapData,
`endif
  output logic                        scanDone
);

  localparam int unsigned CH_W  = clog2_f(NUM_CH);
  localparam int unsigned TMR_W = clog2_f(SCAN_DIV + 1);

  scan_state_e        state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [CH_W-1:0]    cur_ch_q, cur_ch_d;
  logic [PDATA_W-1:0] an_data_q, an_data_d;
  logic               scan_done_q, scan_done_d;
  logic               alarm_any_q;
  logic               eval_c;
  logic [NUM_CH-1:0]  alarm_nx;
  logic [PDATA_W-1:0] ch_arr [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_slice
    assign ch_arr[g] = chData[g*PDATA_W +: PDATA_W];
  end

  // Scan sequencer: idle timer, then SEL/EVAL pairs for each channel in order.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    cur_ch_d    = cur_ch_q;
    an_data_d   = an_data_q;
    scan_done_d = 1'b0;
    eval_c      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          if (timer_q == TMR_W'(SCAN_DIV - 1)) begin
            timer_d  = '0;
            cur_ch_d = '0;
            state_d  = ST_SEL;
          end else begin
            timer_d = timer_q + TMR_W'(1);
          end
        end else begin
          timer_d = '0;
        end
      end
      ST_SEL: begin
        an_data_d = ch_arr[cur_ch_q];
        state_d   = ST_EVAL;
      end
      ST_EVAL: begin
        eval_c = 1'b1;
        if (cur_ch_q == CH_W'(NUM_CH - 1)) begin
          scan_done_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          cur_ch_d = cur_ch_q + CH_W'(1);
          state_d  = ST_SEL;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      cur_ch_q    <= '0;
      an_data_q   <= '0;
      scan_done_q <= 1'b0;
      alarm_any_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      cur_ch_q    <= cur_ch_d;
      an_data_q   <= an_data_d;
      scan_done_q <= scan_done_d;
      alarm_any_q <= |alarm_nx;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pressure_ch_filter #(
      .CONFIRM   (CONFIRM)
    ) u_filt (
      .clk       (clk),
      .rst_n     (rst_n),
      .update_i  (eval_c && (cur_ch_q == CH_W'(i))),
      .warn_i    (anWarning),
      .ack_i     (ackAlarm[i]),
`ifdef PRESSURE_SNAPSHOT_EN
      .data_i    (an_data_q),
      .snap_o    (snapData[i*PDATA_W +: PDATA_W]),
`endif
      .alarm_o   (alarm[i]),
      .alarm_d_c (alarm_nx[i])
    );
  end

  assign anData   = an_data_q;
  assign curCh    = cur_ch_q;
  assign scanDone = scan_done_q;
  assign alarmAny = alarm_any_q;

endmodule

// File: tb/tb_pressure_scan_controller.sv
// Directed bench for pressure_scan_controller at default parameters, with a simple analyzer model.
module tb_pressure_scan_controller;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [23:0] chData;
  logic [5:0]  anData;
  logic        anWarning;
  logic [3:0]  ackAlarm;
  logic [3:0]  alarm;
  logic        alarmAny;
  logic [1:0]  curCh;
  logic        scanDone;
`ifdef PRESSURE_SNAPSHOT_EN
  logic [23:0] snapData;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [23:0] data;
    logic [3:0]  exp_alarm;
    int          exp_chg;
  } scan_vec_t;

  scan_vec_t vecs [6];

  pressure_scan_controller dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .chData    (chData),
    .anData    (anData),
    .anWarning (anWarning),
    .ackAlarm  (ackAlarm),
    .alarm     (alarm),
    .alarmAny  (alarmAny),
    .curCh     (curCh),
`ifdef PRESSURE_SNAPSHOT_EN
    .snapData  (snapData),
`endif
    .scanDone  (scanDone)
  );

  // Analyzer stand-in: samples 1..15 warn; 0 and 29 do not.
  assign anWarning = (anData != 6'd0) && (anData < 6'd16);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Runs from a scan boundary to the next scanDone; records the first cycle alarm changes.
  task automatic run_scan(input logic [23:0] data, input logic [3:0] exp_alarm,
                          input int exp_chg, input string tag);
    logic [3:0] a0;
    int n;
    int chg;
    bit done;
    a0   = alarm;
    n    = 0;
    chg  = 0;
    done = 1'b0;
    chData = data;
    while (!done && n < 64) begin
      @(negedge clk);
      n++;
      if (chg == 0 && alarm !== a0) chg = n;
      if (scanDone) done = 1'b1;
    end
    check({tag, "_period"}, 32'(n), 32'd16);
    check({tag, "_alarm"}, 32'(alarm), 32'(exp_alarm));
    check({tag, "_alarmAny"}, 32'(alarmAny), 32'(|exp_alarm));
    check({tag, "_chg_cycle"}, 32'(chg), 32'(exp_chg));
  endtask

  initial begin
    int pulses;
    rst_n    = 1'b0;
    enable   = 1'b1;
    chData   = 24'h0;
    ackAlarm = 4'b0000;
    repeat (3) @(negedge clk);
    check("rst_alarm", 32'(alarm), 32'd0);
    check("rst_alarmAny", 32'(alarmAny), 32'd0);
    check("rst_scanDone", 32'(scanDone), 32'd0);
    check("rst_curCh", 32'(curCh), 32'd0);
    check("rst_anData", 32'(anData), 32'd0);

    rst_n = 1'b1;
    run_scan(24'h000000, 4'b0000, 0, "first_scan");

    // ch2 constant warning; ch1 alternates warn / no-warn; ch3=29 and ch0 once warned.
    vecs[0] = '{data: 24'h002080, exp_alarm: 4'b0000, exp_chg: 0};
    vecs[1] = '{data: 24'h002740, exp_alarm: 4'b0000, exp_chg: 0};
    vecs[2] = '{data: 24'h002080, exp_alarm: 4'b0100, exp_chg: 14};
    vecs[3] = '{data: 24'h742740, exp_alarm: 4'b0100, exp_chg: 0};
    vecs[4] = '{data: 24'h002080, exp_alarm: 4'b0100, exp_chg: 0};
    vecs[5] = '{data: 24'h002742, exp_alarm: 4'b0100, exp_chg: 0};
    for (int i = 0; i < 6; i++) begin
      run_scan(vecs[i].data, vecs[i].exp_alarm, vecs[i].exp_chg, $sformatf("vec%0d", i));
`ifdef PRESSURE_SNAPSHOT_EN
      if (i == 2) check("snap_ch2", 32'(snapData[17:12]), 32'd2);
`endif
    end

    // Ack clears next cycle; saturated counter re-raises at the ch2 EVAL.
    chData   = 24'h002000;
    ackAlarm = 4'b0100;
    @(negedge clk);
    ackAlarm = 4'b0000;
    check("ack_clear_alarm", 32'(alarm), 32'd0);
    check("ack_clear_any", 32'(alarmAny), 32'd0);
    repeat (12) @(negedge clk);
    check("ack_pre_reset_alarm", 32'(alarm), 32'd0);
    check("ack_anData_ch2", 32'(anData), 32'd2);
    check("ack_curCh_ch2", 32'(curCh), 32'd2);
    @(negedge clk);
    check("ack_reraise_alarm", 32'(alarm), 32'b0100);
    check("ack_reraise_any", 32'(alarmAny), 32'd1);
    repeat (2) @(negedge clk);
    check("ack_scanDone", 32'(scanDone), 32'd1);

    // Ack coincident with set: set wins.
    repeat (13) @(negedge clk);
    ackAlarm = 4'b0100;
    @(negedge clk);
    ackAlarm = 4'b0000;
    check("ack_vs_set_alarm", 32'(alarm), 32'b0100);
    check("ack_vs_set_any", 32'(alarmAny), 32'd1);
    repeat (2) @(negedge clk);
    check("ack_vs_set_scanDone", 32'(scanDone), 32'd1);

    // Drop enable during SEL of ch1: scan completes, then FSM parks with timer at 0.
    repeat (10) @(negedge clk);
    check("drop_curCh_sel1", 32'(curCh), 32'd1);
    enable = 1'b0;
    repeat (6) @(negedge clk);
    check("drop_scanDone", 32'(scanDone), 32'd1);
    check("drop_curCh_last", 32'(curCh), 32'd3);
    pulses = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (scanDone) pulses++;
    end
    check("drop_idle_pulses", 32'(pulses), 32'd0);
    check("drop_idle_curCh", 32'(curCh), 32'd3);
    enable = 1'b1;
    repeat (7) @(negedge clk);
    check("reen_curCh_m7", 32'(curCh), 32'd3);
    @(negedge clk);
    check("reen_curCh_m8", 32'(curCh), 32'd0);
    repeat (8) @(negedge clk);
    check("reen_scanDone", 32'(scanDone), 32'd1);
    check("reen_alarm", 32'(alarm), 32'b0100);

    // Async reset during EVAL of ch2 with alarm[2] set.
    repeat (13) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_alarm", 32'(alarm), 32'd0);
    check("arst_alarmAny", 32'(alarmAny), 32'd0);
    check("arst_curCh", 32'(curCh), 32'd0);
    check("arst_anData", 32'(anData), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_scan(24'h002000, 4'b0000, 0, "post_rst1");
    run_scan(24'h002000, 4'b0000, 0, "post_rst2");
    run_scan(24'h002000, 4'b0100, 14, "post_rst3");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
